// File: rtl/mux_display_capture.sv
// mux_display_capture
//   Receive side of the 4-digit multiplexed 7-segment scan bus. Watches the
//   active-low anode strobes an3..an0 and the shared 4-bit char code, and
//   rebuilds complete frames (an3 first, an0 last). A complete frame is
//   committed to digit3..digit0 together with a one-cycle frame_valid pulse.
//   Malformed scans give a one-cycle frame_err pulse. link_lost is raised
//   after TIMEOUT clocks without an accepted strobe.
//
// Ports
//   clk                     system clock, rising edge
//   reset                   asynchronous reset, active low
//   an3, an2, an1, an0      active-low digit strobes (scan order 3 -> 0)
//   char[3:0]               code for the strobed digit
//   digit3..digit0[3:0]     last committed frame
//   frame_valid             1-cycle pulse when the digits are updated
//   frame_err               1-cycle pulse on a malformed scan
//   link_lost               level, no accepted strobe for TIMEOUT clocks
//   frame_cnt[7:0]          (MUX_CAPTURE_FRAME_CNT_EN) committed frames, wraps
//   err_cnt[7:0]            (MUX_CAPTURE_FRAME_CNT_EN) frame errors, saturates
//
// Parameter
//   TIMEOUT (2..255, default 64)
//
// Optional feature macro: MUX_CAPTURE_FRAME_CNT_EN adds frame_cnt / err_cnt.

module mux_display_capture #(
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       an3,
    input  logic       an2,
    input  logic       an1,
    input  logic       an0,
    input  logic [3:0] char,
    output logic [3:0] digit3,
    output logic [3:0] digit2,
    output logic [3:0] digit1,
    output logic [3:0] digit0,
    output logic       frame_valid,
    output logic       frame_err,
    output logic       link_lost
`ifdef MUX_CAPTURE_FRAME_CNT_EN
    ,
    output logic [7:0] frame_cnt,
    output logic [7:0] err_cnt
`endif
);

    localparam logic [7:0] TO = 8'(TIMEOUT);

    typedef enum logic [1:0] {WAIT3, WAIT2, WAIT1, WAIT0} state_t;

    state_t           state, state_nxt;
    logic [3:1][3:0]  shadow, shadow_nxt;
    logic [7:0]       cnt, cnt_nxt;
    logic [3:0]       an, low, prev_an, ev;
    logic             illegal, accept, commit, err, lost_set;

    assign an  = {an3, an2, an1, an0};
    assign low = ~an;
    // Falling edge of a strobe; prev_an resets high so a strobe already low
    // when reset releases still counts once.
    assign ev  = low & prev_an;
    // Two or more strobes low: clearing the lowest set bit leaves something.
    assign illegal = |(low & (low - 4'd1));

    always_comb begin
        state_nxt  = state;
        shadow_nxt = shadow;
        accept     = 1'b0;
        commit     = 1'b0;
        err        = 1'b0;
        lost_set   = 1'b0;

        if (illegal) begin
            err        = 1'b1;
            state_nxt  = WAIT3;
            shadow_nxt = '0;
        end else if (ev[3]) begin
            // an3 always (re)starts a frame; mid-frame it is also an error.
            shadow_nxt[3] = char;
            state_nxt     = WAIT2;
            accept        = 1'b1;
            err           = (state != WAIT3);
        end else if (ev != 4'd0 && state != WAIT3) begin
            unique case (state)
                WAIT2: if (ev[2]) begin
                    shadow_nxt[2] = char;
                    state_nxt     = WAIT1;
                    accept        = 1'b1;
                end
                WAIT1: if (ev[1]) begin
                    shadow_nxt[1] = char;
                    state_nxt     = WAIT0;
                    accept        = 1'b1;
                end
                WAIT0: if (ev[0]) begin
                    commit    = 1'b1;
                    state_nxt = WAIT3;
                    accept    = 1'b1;
                end
                default: ;
            endcase
            if (!accept) begin
                err        = 1'b1;
                state_nxt  = WAIT3;
                shadow_nxt = '0;
            end
        end
        // Events outside a frame while in WAIT3 fall through: silent resync.

        cnt_nxt = accept ? 8'd0 : ((cnt == TO) ? TO : cnt + 8'd1);

        // An illegal cycle suppresses the timeout; an accepted event (and so
        // any commit) has already cleared the counter.
        if (!illegal && !accept && cnt_nxt == TO) begin
            lost_set   = 1'b1;
            state_nxt  = WAIT3;
            shadow_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= WAIT3;
            shadow      <= '0;
            cnt         <= 8'd0;
            prev_an     <= 4'hF;
            digit3      <= 4'd0;
            digit2      <= 4'd0;
            digit1      <= 4'd0;
            digit0      <= 4'd0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            link_lost   <= 1'b0;
        end else begin
            state       <= state_nxt;
            shadow      <= shadow_nxt;
            cnt         <= cnt_nxt;
            prev_an     <= an;
            frame_valid <= commit;
            frame_err   <= err;
            if (commit) begin
                digit3 <= shadow[3];
                digit2 <= shadow[2];
                digit1 <= shadow[1];
                digit0 <= char;
            end
            if (commit)
                link_lost <= 1'b0;
            else if (lost_set)
                link_lost <= 1'b1;
        end
    end

`ifdef MUX_CAPTURE_FRAME_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt <= 8'd0;
            err_cnt   <= 8'd0;
        end else begin
            if (commit)
                frame_cnt <= frame_cnt + 8'd1;
            if (err && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule
